// File: rtl/cla_dispatch.sv
// cla_dispatch: issue/writeback wrapper around the external 16-bit CLA.
// Holds an 8 x 16 register file and a busy-bit scoreboard. Issued add
// operands go out through a registered execute stage, and the adder sum is
// committed two cycles after issue.
module cla_dispatch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  instr_rd,
  input  logic [2:0]  instr_rs1,
  input  logic [2:0]  instr_rs2,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic [15:0] opa,
  output logic [15:0] opb,
  input  logic [15:0] sum,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        ovf,
  output logic [7:0]  busy,
  output logic [15:0] retired,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 8;

  // r0 is held at zero by never being written, so reads need no zero mux
  logic [DW-1:0] rf [NR];

  logic          e_v;
  logic [AW-1:0] e_rd;
  logic          w_v;
  logic [AW-1:0] w_rd;
  logic [DW-1:0] w_data;

  logic          hazard_c;
  logic          issue_c;
  logic          load_c;
  logic          ovf_c;
  logic [NR-1:0] busy_nxt_c;

  // Handshake: loads win over issue; loads only into a drained pipeline
  always_comb begin
    hazard_c    = busy[instr_rs1] | busy[instr_rs2] | busy[instr_rd];
    instr_ready = !hazard_c && !ld_valid;
    ld_ready    = (busy == NR'(0)) && !e_v && !w_v;
    issue_c     = instr_valid && instr_ready;
    load_c      = ld_valid && ld_ready;
  end

  // Scoreboard update: writeback clears first, issue sets after (set wins)
  always_comb begin
    busy_nxt_c = busy;
    if (w_v)
      busy_nxt_c[w_rd] = 1'b0;
    if (issue_c && (instr_rd != AW'(0)))
      busy_nxt_c[instr_rd] = 1'b1;
    busy_nxt_c[0] = 1'b0;
  end

  // Signed overflow of the add currently in execute
  always_comb begin
    ovf_c = e_v && (opa[DW-1] == opb[DW-1]) && (sum[DW-1] != opa[DW-1]);
  end

  // Register file: preload or writeback (never both, ld_ready excludes w_v)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++)
        rf[i] <= DW'(0);
    end else if (load_c) begin
      if (ld_addr != AW'(0))
        rf[ld_addr] <= ld_data;
    end else if (w_v) begin
      if (w_rd != AW'(0))
        rf[w_rd] <= w_data;
    end
  end

  // Issue, execute and writeback pipeline registers plus status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa     <= DW'(0);
      opb     <= DW'(0);
      e_v     <= 1'b0;
      e_rd    <= AW'(0);
      w_v     <= 1'b0;
      w_rd    <= AW'(0);
      w_data  <= DW'(0);
      busy    <= NR'(0);
      ovf     <= 1'b0;
      retired <= DW'(0);
    end else begin
      if (issue_c) begin
        opa  <= rf[instr_rs1];
        opb  <= rf[instr_rs2];
        e_rd <= instr_rd;
      end
      e_v <= issue_c;
      w_v <= e_v;
      if (e_v) begin
        w_data <= sum;
        w_rd   <= e_rd;
      end
      busy <= busy_nxt_c;
      if (ovf_c)
        ovf <= 1'b1;
      if (w_v)
        retired <= retired + DW'(1);
    end
  end

  // Writeback port mirrors the W stage register
  always_comb begin
    wb_valid = w_v;
    wb_rd    = w_rd;
    wb_data  = w_data;
  end

  // Debug read shows the current (pre-write) contents
  always_comb begin
    dbg_data = rf[dbg_addr];
  end

endmodule

// File: tb/tb_cla_dispatch.sv
// Self-checking bench for cla_dispatch; the bench itself plays the adder.
module tb_cla_dispatch;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_rd;
  logic [2:0]  instr_rs1;
  logic [2:0]  instr_rs2;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [15:0] sum;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        ovf;
  logic [7:0]  busy;
  logic [15:0] retired;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_tests;
  int n_fail;
  int exp_ret;

  cla_dispatch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .opa         (opa),
    .opb         (opb),
    .sum         (sum),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .ovf         (ovf),
    .busy        (busy),
    .retired     (retired),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural 16-bit adder standing in for the CLA, carry-out dropped
  assign sum = 16'(opa + opb);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rd;
    logic [15:0] exp_sum;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] addr, input logic [15:0] data);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    #1;
    chk("ld_ready_idle", 16'(ld_ready), 16'h1);
    chk("instr_blocked_by_ld", 16'(instr_ready), 16'h0);
    step();
    ld_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    int n;
    instr_valid = 1'b1;
    instr_rd    = rd;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    #1;
    n = 0;
    while (!instr_ready && n < 20) begin
      n++;
      step();
    end
    if (!instr_ready) begin
      chk("issue_timeout", 16'(instr_ready), 16'h1);
    end
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    int stall;
    n_tests     = 0;
    n_fail      = 0;
    exp_ret     = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_rd    = 3'd0;
    instr_rs1   = 3'd0;
    instr_rs2   = 3'd0;
    ld_valid    = 1'b0;
    ld_addr     = 3'd0;
    ld_data     = 16'h0;
    dbg_addr    = 3'd0;

    vecs[0] = '{16'h007B, 16'h0064, 3'd3, 16'h00DF, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 3'd6, 16'h5555, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 3'd4, 16'h8000, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0001, 3'd5, 16'h0000, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 3'd7, 16'h0000, 1'b1};

    // Reset state
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("rst_instr_ready", 16'(instr_ready), 16'h1);
    chk("rst_ld_ready", 16'(ld_ready), 16'h1);
    chk("rst_wb_valid", 16'(wb_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_retired", retired, 16'h0);
    chk("rst_ovf", 16'(ovf), 16'h0);
    chk("rst_opa", opa, 16'h0);
    dbg_addr = 3'd1;
    #1;
    chk("rst_r1", dbg_data, 16'h0);

    // Table-driven add vectors: r_rd = r1 + r2
    for (int i = 0; i < 5; i++) begin
      do_load(3'd1, vecs[i].a);
      do_load(3'd2, vecs[i].b);
      issue(vecs[i].rd, 3'd1, 3'd2);
      chk("opa", opa, vecs[i].a);
      chk("opb", opb, vecs[i].b);
      chk("ld_ready_inflight", 16'(ld_ready), 16'h0);
      chk("busy_set", 16'(busy[vecs[i].rd]), 16'h1);
      dbg_addr = vecs[i].rd;
      step();
      chk("wb_valid", 16'(wb_valid), 16'h1);
      chk("wb_rd", 16'(wb_rd), 16'(vecs[i].rd));
      chk("wb_data", wb_data, vecs[i].exp_sum);
      chk("dbg_prewrite", dbg_data, 16'h0);
      step();
      exp_ret++;
      chk("wb_valid_pulse", 16'(wb_valid), 16'h0);
      chk("ovf", 16'(ovf), 16'(vecs[i].exp_ovf));
      chk("retired", retired, 16'(exp_ret));
      chk("busy_clear", 16'(busy), 16'h0);
      chk("dbg_written", dbg_data, vecs[i].exp_sum);
    end

    // RAW hazard: r3 = r1 + r2, then r5 = r3 + r1
    do_load(3'd1, 16'h0010);
    do_load(3'd2, 16'h0020);
    issue(3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    instr_rd    = 3'd5;
    instr_rs1   = 3'd3;
    instr_rs2   = 3'd1;
    #1;
    stall = 0;
    while (!instr_ready && stall < 10) begin
      stall++;
      step();
      if (stall == 1) begin
        chk("raw_first_wb_rd", 16'(wb_rd), 16'h3);
        chk("raw_first_wb_data", wb_data, 16'h0030);
      end
    end
    chk("raw_stall_cycles", 16'(stall), 16'h2);
    step();
    instr_valid = 1'b0;
    exp_ret++;
    chk("raw_opa", opa, 16'h0030);
    step();
    chk("raw_wb_valid", 16'(wb_valid), 16'h1);
    chk("raw_wb_rd", 16'(wb_rd), 16'h5);
    chk("raw_wb_data", wb_data, 16'h0040);
    step();
    exp_ret++;
    chk("raw_retired", retired, 16'(exp_ret));

    // Independent back-to-back: r3 = r1 + r2, r4 = r1 + r1
    instr_valid = 1'b1;
    instr_rd    = 3'd3;
    instr_rs1   = 3'd1;
    instr_rs2   = 3'd2;
    #1;
    chk("b2b_ready0", 16'(instr_ready), 16'h1);
    step();
    instr_rd  = 3'd4;
    instr_rs1 = 3'd1;
    instr_rs2 = 3'd1;
    #1;
    chk("b2b_ready1", 16'(instr_ready), 16'h1);
    step();
    instr_valid = 1'b0;
    chk("b2b_wb0_valid", 16'(wb_valid), 16'h1);
    chk("b2b_wb0_rd", 16'(wb_rd), 16'h3);
    chk("b2b_wb0_data", wb_data, 16'h0030);
    step();
    chk("b2b_wb1_valid", 16'(wb_valid), 16'h1);
    chk("b2b_wb1_rd", 16'(wb_rd), 16'h4);
    chk("b2b_wb1_data", wb_data, 16'h0020);
    step();
    exp_ret += 2;
    chk("b2b_idle", 16'(wb_valid), 16'h0);
    chk("b2b_retired", retired, 16'(exp_ret));

    // r0 destination and r0 preload are both discarded
    issue(3'd0, 3'd1, 3'd2);
    chk("r0_busy", 16'(busy), 16'h0);
    step();
    chk("r0_wb_valid", 16'(wb_valid), 16'h1);
    chk("r0_wb_rd", 16'(wb_rd), 16'h0);
    step();
    exp_ret++;
    dbg_addr = 3'd0;
    #1;
    chk("r0_read", dbg_data, 16'h0);
    chk("r0_retired", retired, 16'(exp_ret));
    do_load(3'd0, 16'hABCD);
    #1;
    chk("r0_load_ignored", dbg_data, 16'h0);

    // Reset during the execute cycle of an add
    issue(3'd6, 3'd1, 3'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("mrst_wb_valid", 16'(wb_valid), 16'h0);
    chk("mrst_busy", 16'(busy), 16'h0);
    chk("mrst_retired", retired, 16'h0);
    chk("mrst_ovf", 16'(ovf), 16'h0);
    chk("mrst_instr_ready", 16'(instr_ready), 16'h1);
    chk("mrst_ld_ready", 16'(ld_ready), 16'h1);
    step();
    chk("mrst_no_wb", 16'(wb_valid), 16'h0);
    chk("mrst_retired_hold", retired, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_dispatch.md
# cla_dispatch

Issue/writeback stage wrapped around the 16-bit carry-lookahead adder (`cla`). It holds an 8-entry × 16-bit register file and a busy-bit scoreboard. It accepts add instructions through a valid/ready handshake and stalls on operand or destination hazards. Issued operands go to the adder through a registered execute stage, and the adder sum is written back two cycles after issue.

## Interface
- No parameters. Widths are fixed: 16-bit data, 3-bit register address.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `instr_valid` in 1: add instruction `rd = rs1 + rs2` offered.
- `instr_ready` out 1: instruction accepted on cycles where `instr_valid && instr_ready`.
- `instr_rd`, `instr_rs1`, `instr_rs2` in 3 each: register addresses.
- `ld_valid` in 1: preload request.
- `ld_ready` out 1: preload accepted when `ld_valid && ld_ready`.
- `ld_addr` in 3, `ld_data` in 16: preload target and value.
- `opa`, `opb` out 16: registered operands to the adder. Bit 15 drives `a1`/`b1` (MSB); bit 0 drives `a16`/`b16`.
- `sum` in 16: adder result. `o1` is bit 15, `o16` is bit 0.
- `wb_valid` out 1: one-cycle pulse when a writeback commits.
- `wb_rd` out 3, `wb_data` out 16: the committing writeback.
- `ovf` out 1: sticky signed-overflow flag.
- `busy` out 8: scoreboard bits. Bit 0 is always 0.
- `retired` out 16: count of committed adds.
- `dbg_addr` in 3, `dbg_data` out 16: combinational register-file read.

## Operation
- Register file: r0 always reads 0, and writes to r0 are discarded. r1–r7 reset to 0.
- Hazard check: stall when `busy[rs1] | busy[rs2] | busy[rd]` (RAW and WAW). No bypass paths.
- `instr_ready = !hazard && !ld_valid`. Load has priority over instruction issue.
- Issue (cycle t):
  - `opa <= R[rs1]`, `opb <= R[rs2]`, `e_rd <= rd`, `e_v <= 1`.
  - `busy[rd] <= 1` unless `rd == 0`.
- Execute (cycle t+1): the adder sees `opa`/`opb`. At the closing edge:
  - `w_v <= e_v`, `w_data <= sum`, `w_rd <= e_rd`.
  - Signed overflow (`opa[15] == opb[15] && sum[15] != opa[15]`) sets `ovf`.
- Writeback (cycle t+2):
  - `wb_valid`, `wb_rd`, `wb_data` reflect the W register.
  - At the closing edge: `R[w_rd] <= w_data` (unless r0), `busy[w_rd] <= 0`, `retired <= retired + 1`.
- Arithmetic: result is modulo 2^16. The carry-out is dropped. `retired` wraps from 0xFFFF to 0x0000.
- Load: `ld_ready = (busy == 0) && !e_v && !w_v`. On accept, `R[ld_addr] <= ld_data`; a load to r0 is ignored.
- Pipeline: `e_v` and `w_v` are the only state, so the pipeline is at most 2 deep. Back-to-back independent issues are allowed every cycle.

## Timing
- Reset values (rising edge with `rst_n = 0`):
  - All registers, `opa`, `opb`, `busy`, `ovf` and `retired` are 0.
  - `e_v` and `w_v` are 0, so `wb_valid` is 0.
  - `instr_ready = 1` and `ld_ready = 1` the following cycle.
- Reset mid-operation: in-flight adds are discarded, with no writeback and no `retired` increment.
- Latency: issue edge E0 → `opa`/`opb` valid after E0 → `wb_valid` high in the cycle after E1 → register written and busy cleared at E2.
- Dependent issue: the earliest dependent instruction is accepted in the cycle after E2, i.e. 3 cycles after the producer.
- Writeback/issue on the same edge:
  - Clearing `busy[x]` and setting `busy[y]` on one edge: both take effect.
  - If `x == y`, set wins. This case cannot arise while the hazard check blocks rd-busy, but the logic must still resolve it.
- `dbg_data` is combinational. It shows the pre-write value during the writeback cycle.
- `ovf` clears only on reset.

## Test plan
- Reset, then preload r1 = 0x007B and r2 = 0x0064, issue r3 = r1 + r2 → `wb_valid` 2 cycles after issue with `wb_rd = 3`, `wb_data = 0x00DF`, `retired = 1`, `ovf = 0`.
- Preload r1 = 0x7FFF and r2 = 0x0001, issue r4 = r1 + r2 → `wb_data = 0x8000`, `ovf = 1`. Then r5 = 0xFFFF + 0x0001 → `wb_data = 0x0000`, `ovf` stays 1.
- RAW: issue r3 = r1 + r2, then immediately r5 = r3 + r1 → `instr_ready` is low for 2 cycles, and the second add is accepted the cycle after the r3 writeback with the correct sum.
- Independent back-to-back: r3 = r1 + r2 then r4 = r1 + r1 on consecutive cycles → both accepted with no stall, writebacks on consecutive cycles.
- r0 handling: issue r0 = r1 + r2 → `wb_valid` pulses, `busy[0]` stays 0, `dbg_data` for r0 reads 0. A load to r0 is ignored.
- Assert `rst_n = 0` in the execute cycle of an add → no `wb_valid`, `busy = 0`, `retired = 0`. Ready signals go high after release.
